// File: rtl/led_seq_pkg.sv
// Shared types for the LED blink sequencer: pattern modes and FSM states.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/tick_edge_sync.sv
// Three-flop synchroniser for an asynchronous level, plus a registered
// single-cycle pulse on each synchronised rising edge.
module tick_edge_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;
  logic rise_reg;

  // s1 is the metastability catcher; edges are judged only from s2/s3.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      s1_reg   <= async_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      rise_reg <= s2_reg & ~s3_reg;
    end
  end

  assign rise_pulse = rise_reg;

endmodule

// File: rtl/led_blink_sequencer.sv
// Advances an LED pattern on each synchronised slow tick and gates the lit
// LEDs with a PWM brightness mask before driving the board pins.
module led_blink_sequencer
  import led_seq_pkg::*;
#(
  parameter int          N_LED          = 5,
  parameter int          BW             = 4,
  parameter logic        LED_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [BW-1:0]    brightness,
  output logic [N_LED-1:0] led,
  output logic             busy
);

  localparam logic [N_LED-1:0] LED_DARK = {N_LED{LED_ACTIVE_LOW}};
  localparam logic [N_LED-1:0] PAT_ZERO = '0;
  localparam logic [N_LED-1:0] PAT_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    PWM_MAX  = '1;
  localparam logic [BW-1:0]    PWM_ONE  = {{(BW-1){1'b0}}, 1'b1};

  state_e           state_reg;
  mode_e            mode_q_reg;
  logic [N_LED-1:0] pattern_reg;
  logic [BW-1:0]    bright_q_reg;
  logic [BW-1:0]    pwm_cnt_reg;
  logic [N_LED-1:0] led_reg;
  logic             busy_reg;

  logic  step;
  logic  pwm_on;
  mode_e mode_in;

  function automatic logic [N_LED-1:0] init_pattern(input mode_e m);
    case (m)
      MODE_BLINK: init_pattern = '1;
      MODE_RUN:   init_pattern = PAT_ONE;
      default:    init_pattern = PAT_ZERO;
    endcase
  endfunction

  function automatic logic [N_LED-1:0] advance_pattern(input mode_e m,
                                                       input logic [N_LED-1:0] p);
    case (m)
      MODE_BLINK: advance_pattern = ~p;
      MODE_RUN:   advance_pattern = {p[N_LED-2:0], p[N_LED-1]};
      MODE_COUNT: advance_pattern = p + PAT_ONE;
      default:    advance_pattern = PAT_ZERO;
    endcase
  endfunction

  tick_edge_sync u_tick_sync (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .async_in   (tick_in),
    .rise_pulse (step)
  );

  assign mode_in = mode_e'(mode);
  assign pwm_on  = (pwm_cnt_reg < bright_q_reg);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      mode_q_reg   <= MODE_OFF;
      pattern_reg  <= PAT_ZERO;
      bright_q_reg <= '0;
      pwm_cnt_reg  <= '0;
      led_reg      <= LED_DARK;
      busy_reg     <= 1'b0;
    end else begin
      // Output stage lags the pattern by one edge and stays dark outside RUN.
      if (state_reg == ST_RUN) begin
        led_reg <= (pattern_reg & {N_LED{pwm_on}}) ^ LED_DARK;
      end else begin
        led_reg <= LED_DARK;
      end

      case (state_reg)
        ST_IDLE: begin
          pattern_reg <= PAT_ZERO;
          pwm_cnt_reg <= '0;
          busy_reg    <= 1'b0;
          if (enable) begin
            state_reg <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          mode_q_reg   <= mode_in;
          pattern_reg  <= init_pattern(mode_in);
          bright_q_reg <= brightness;
          pwm_cnt_reg  <= '0;
          busy_reg     <= 1'b1;
          state_reg    <= ST_RUN;
        end

        ST_RUN: begin
          if (!enable) begin
            state_reg   <= ST_IDLE;
            pattern_reg <= PAT_ZERO;
            pwm_cnt_reg <= '0;
            busy_reg    <= 1'b0;
          end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_ONE;
            // Duty only changes at a period boundary so no partial period glitches.
            if (pwm_cnt_reg == PWM_MAX) begin
              bright_q_reg <= brightness;
            end
            if (step) begin
              if (mode_in != mode_q_reg) begin
                mode_q_reg  <= mode_in;
                pattern_reg <= init_pattern(mode_in);
              end else begin
                pattern_reg <= advance_pattern(mode_q_reg, pattern_reg);
              end
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign led  = led_reg;
  assign busy = busy_reg;

endmodule
